// File: rtl/synapse_event_driver.sv
// Synapse event driver: buffers address-event spike IDs in a small FIFO, looks up each
// ID's signed-magnitude weight in a runtime-writable RAM and emits one synaptic event
// per cycle towards a LIF neuron through a three-stage pipeline.
module synapse_event_driver #(
    parameter int unsigned NUM_INPUTS   = 64,
    parameter int unsigned ID_WIDTH     = 6,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            enable_i,
    input  logic                            flush_i,
    input  logic                            s_spike_valid_i,
    input  logic [ID_WIDTH-1:0]             s_spike_id_i,
    output logic                            s_spike_ready_o,
    input  logic                            cfg_we_i,
    input  logic [ID_WIDTH-1:0]             cfg_addr_i,
    input  logic [WEIGHT_WIDTH:0]           cfg_wdata_i,
    output logic                            syn_valid_o,
    output logic [WEIGHT_WIDTH-1:0]         syn_weight_o,
    output logic                            syn_excitatory_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
    output logic                            busy_o,
    output logic [15:0]                     dropped_ids_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ID_WIDTH-1:0]     fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic                    full, empty, push, pop;
    logic [ID_WIDTH-1:0]     head_id;
    logic                    head_in_range;

    logic [WEIGHT_WIDTH:0]   ram_q [NUM_INPUTS];
    logic [WEIGHT_WIDTH:0]   ram_rdata;

    logic                    s1_valid_q, s1_valid_d;
    logic [WEIGHT_WIDTH:0]   s1_word_q, s1_word_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [WEIGHT_WIDTH-1:0] s2_weight_q, s2_weight_d;
    logic                    s2_exc_q, s2_exc_d;
    logic [15:0]             dropped_q, dropped_d;

    // FIFO status, handshakes and the stage-0 RAM read address.
    always_comb begin
        full          = (count_q == CntW'(FIFO_DEPTH));
        empty         = (count_q == '0);
        // A push coinciding with flush is discarded.
        push          = s_spike_valid_i && !full && !flush_i;
        pop           = enable_i && !empty && !flush_i;
        head_id       = fifo_mem_q[rd_ptr_q];
        head_in_range = (32'(head_id) < NUM_INPUTS);
        ram_rdata     = head_in_range ? ram_q[head_id] : '0;
    end

    // FIFO pointer and occupancy next-state; pointers wrap because depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pipeline next-state: stages hold while disabled, flush clears the valids only.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_word_d   = s1_word_q;
        s2_valid_d  = s2_valid_q;
        s2_weight_d = s2_weight_q;
        s2_exc_d    = s2_exc_q;
        dropped_d   = dropped_q;
        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else if (enable_i) begin
            s1_valid_d = pop && head_in_range;
            s1_word_d  = ram_rdata;
            // Zero-magnitude weights update the data outputs but never raise syn_valid.
            s2_valid_d = s1_valid_q && (s1_word_q[WEIGHT_WIDTH-1:0] != '0);
            if (s1_valid_q) begin
                s2_weight_d = s1_word_q[WEIGHT_WIDTH-1:0];
                s2_exc_d    = s1_word_q[WEIGHT_WIDTH];
            end
            if (pop && !head_in_range && (dropped_q != 16'hFFFF)) begin
                dropped_d = dropped_q + 16'd1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_word_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_weight_q <= '0;
            s2_exc_q    <= 1'b0;
            dropped_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            s1_valid_q  <= s1_valid_d;
            s1_word_q   <= s1_word_d;
            s2_valid_q  <= s2_valid_d;
            s2_weight_q <= s2_weight_d;
            s2_exc_q    <= s2_exc_d;
            dropped_q   <= dropped_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem_q[wr_ptr_q] <= s_spike_id_i;
    end

    // Weight RAM: synchronous write, read-first because stage 1 samples the old word.
    always_ff @(posedge clk_i) begin
        if (cfg_we_i && (32'(cfg_addr_i) < NUM_INPUTS)) ram_q[cfg_addr_i] <= cfg_wdata_i;
    end

    // Outputs derived from registered state.
    always_comb begin
        s_spike_ready_o  = !full;
        syn_valid_o      = s2_valid_q && enable_i && !flush_i;
        syn_weight_o     = s2_weight_q;
        syn_excitatory_o = s2_exc_q;
        fifo_count_o     = count_q;
        busy_o           = !empty || s1_valid_q || s2_valid_q;
        dropped_ids_o    = dropped_q;
    end

endmodule

// File: tb/tb_synapse_event_driver.sv
// Scoreboard bench for synapse_event_driver: stimulus pushes hand-computed expected
// events into a queue, a negedge monitor pops and compares on every syn_valid.
module tb_synapse_event_driver;

    localparam int unsigned NumInputs = 40;
    localparam int unsigned IdW       = 6;
    localparam int unsigned WW        = 8;
    localparam int unsigned Depth     = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic [IdW-1:0] s_id = '0;
    logic          s_ready;
    logic          cfg_we = 1'b0;
    logic [IdW-1:0] cfg_addr = '0;
    logic [WW:0]   cfg_wdata = '0;
    logic          syn_valid;
    logic [WW-1:0] syn_weight;
    logic          syn_exc;
    logic [3:0]    fifo_count;
    logic          busy;
    logic [15:0]   dropped;

    int checks = 0;
    int errors = 0;
    logic [WW:0] exp_q[$];   // {excitatory, weight}

    synapse_event_driver #(
        .NUM_INPUTS  (NumInputs),
        .ID_WIDTH    (IdW),
        .WEIGHT_WIDTH(WW),
        .FIFO_DEPTH  (Depth)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .enable_i        (enable),
        .flush_i         (flush),
        .s_spike_valid_i (s_valid),
        .s_spike_id_i    (s_id),
        .s_spike_ready_o (s_ready),
        .cfg_we_i        (cfg_we),
        .cfg_addr_i      (cfg_addr),
        .cfg_wdata_i     (cfg_wdata),
        .syn_valid_o     (syn_valid),
        .syn_weight_o    (syn_weight),
        .syn_excitatory_o(syn_exc),
        .fifo_count_o    (fifo_count),
        .busy_o          (busy),
        .dropped_ids_o   (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every emitted event must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && syn_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got w=0x%0h exc=%0b, expected none",
                         syn_weight, syn_exc);
            end else begin
                logic [WW:0] e;
                e = exp_q.pop_front();
                if ({syn_exc, syn_weight} !== e) begin
                    errors++;
                    $display("FAIL event: got exc=%0b w=0x%0h, expected exc=%0b w=0x%0h",
                             syn_exc, syn_weight, e[WW], e[WW-1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ram_write(input int addr, input logic [WW:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = IdW'(addr);
        cfg_wdata = data;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic push(input int id);
        s_valid = 1'b1;
        s_id    = IdW'(id);
        step();
        s_valid = 1'b0;
    endtask

    // Bounded drain: busy must fall and every expected event must have been seen.
    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && busy; i++) step();
        step();
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int max_cnt;
        // Reset state
        #12;
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_syn_valid", 32'(syn_valid), 32'd0);
        check("rst_outputs", {syn_exc, syn_weight}, 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_ready", 32'(s_ready), 32'd1);

        // Latency: push ID 5 at E0, event visible in the cycle after E0+2
        ram_write(5, {1'b1, 8'h20});
        exp_q.push_back({1'b1, 8'h20});
        push(5);
        step();
        check("lat_e1_valid", 32'(syn_valid), 32'd0);
        step();
        check("lat_e2_valid", 32'(syn_valid), 32'd1);
        check("lat_e2_word", {syn_exc, syn_weight}, {23'd0, 1'b1, 8'h20});
        step();
        check("lat_busy_low", 32'(busy), 32'd0);

        // Back-to-back IDs 0..7
        for (int i = 0; i < 8; i++) ram_write(i, {i[0], 8'(8'h10 + i)});
        max_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({i[0], 8'(8'h10 + i)});
            s_valid = 1'b1;
            s_id    = IdW'(i);
            step();
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
        s_valid = 1'b0;
        wait_idle("b2b");
        check("b2b_max_count_le2", 32'(max_cnt <= 2), 32'd1);

        // Fill while disabled: ready drops after eight pushes
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({i[0], 8'(8'h10 + i)});
            push(i);
        end
        check("full_count", 32'(fifo_count), 32'd8);
        check("full_ready", 32'(s_ready), 32'd0);
        push(0);
        check("full_ninth_ignored", 32'(fifo_count), 32'd8);
        check("disabled_no_valid", 32'(syn_valid), 32'd0);
        enable = 1'b1;
        wait_idle("full");

        // Zero-weight suppression and out-of-range drop
        ram_write(3, {1'b0, 8'h00});
        ram_write(4, {1'b0, 8'h10});
        exp_q.push_back({1'b0, 8'h10});
        push(3);
        push(4);
        wait_idle("zero");
        push(63);
        wait_idle("oor");
        check("oor_dropped", 32'(dropped), 32'd1);

        // Read-first: write RAM[7] in the cycle its pop reads the RAM
        ram_write(7, {1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h01});
        push(7);
        ram_write(7, {1'b0, 8'h05});
        wait_idle("rf_old");
        exp_q.push_back({1'b0, 8'h05});
        push(7);
        wait_idle("rf_new");

        // Flush with four queued events
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push(i);
        check("flush_pre_count", 32'(fifo_count), 32'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_count", 32'(fifo_count), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_ready", 32'(s_ready), 32'd1);
        enable = 1'b1;
        repeat (6) step();
        check("flush_no_valid", 32'(syn_valid), 32'd0);

        // Asynchronous reset mid-stream
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push(i);
        enable = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(fifo_count), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(syn_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("arst_ready", 32'(s_ready), 32'd1);
        repeat (8) step();
        check("arst_no_stale_busy", 32'(busy), 32'd0);
        check("arst_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
